// File: rtl/maze_loader.sv
// rtl/maze_loader.sv - maze game core: loads an 8x8 maze from a map ROM and walks a player through it
module maze_loader #(
  parameter int MOVE_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  output logic                  rom_en,
  output logic [3:0]            rom_addr,
  input  logic [7:0]            rom_data,
  input  logic                  move_valid,
  input  logic [1:0]            move_dir,
  output logic                  move_ready,
  output logic [2:0]            pos_row,
  output logic [2:0]            pos_col,
  output logic                  ready,
  output logic                  win,
  output logic                  bump,
  output logic [MOVE_CNT_W-1:0] move_count
);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, WON} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              fcnt_q, fcnt_d;     // fetch step: cycles since the load edge
  logic [7:0][7:0]         maze_q, maze_d;     // maze_q[row][7-col] = 1 means open
  logic [5:0]              start_q, start_d;
  logic [5:0]              end_q, end_d;
  logic [2:0]              row_q, row_d;
  logic [2:0]              col_q, col_d;
  logic [MOVE_CNT_W-1:0]   moves_q, moves_d;
  logic                    bump_q, bump_d;

  logic [2:0]              tgt_row, tgt_col;
  logic                    in_bounds, tgt_open, accept;
  logic [2:0]              widx;

  assign move_ready = (state_q == PLAY);
  assign ready      = (state_q == PLAY) || (state_q == WON);
  assign win        = (state_q == WON);
  assign bump       = bump_q;
  assign pos_row    = row_q;
  assign pos_col    = col_q;
  assign move_count = moves_q;

  // Next-state, ROM request and move evaluation
  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    maze_d    = maze_q;
    start_d   = start_q;
    end_d     = end_q;
    row_d     = row_q;
    col_d     = col_q;
    moves_d   = moves_q;
    bump_d    = 1'b0;
    rom_en    = 1'b0;
    rom_addr  = 4'd0;
    widx      = 3'(fcnt_q - 4'd1);
    tgt_row   = row_q;
    tgt_col   = col_q;
    in_bounds = 1'b1;

    // Target cell; edges never wrap, the 3-bit overflow is simply flagged out of bounds
    case (move_dir)
      2'b00: begin in_bounds = (row_q != 3'd0); tgt_row = row_q - 3'd1; end
      2'b01: begin in_bounds = (row_q != 3'd7); tgt_row = row_q + 3'd1; end
      2'b10: begin in_bounds = (col_q != 3'd0); tgt_col = col_q - 3'd1; end
      default: begin in_bounds = (col_q != 3'd7); tgt_col = col_q + 3'd1; end
    endcase
    tgt_open = in_bounds && maze_q[tgt_row][3'd7 - tgt_col];
    accept   = (state_q == PLAY) && move_valid && !load;

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = FETCH;
          fcnt_d  = 4'd0;
        end
      end
      FETCH: begin
        // Address i is issued at step i; its data is back one step later
        if (fcnt_q <= 4'd9) begin
          rom_en   = 1'b1;
          rom_addr = fcnt_q;
        end
        if (fcnt_q != 4'd10) fcnt_d = fcnt_q + 4'd1;
        if (fcnt_q >= 4'd1 && fcnt_q <= 4'd8) maze_d[widx] = rom_data;
        if (fcnt_q == 4'd9) start_d = rom_data[5:0];
        if (fcnt_q == 4'd10) begin
          end_d   = rom_data[5:0];
          row_d   = start_q[5:3];
          col_d   = start_q[2:0];
          moves_d = '0;
          state_d = (start_q == rom_data[5:0]) ? WON : PLAY;
        end
      end
      PLAY: begin
        if (load) begin
          state_d = FETCH;
          fcnt_d  = 4'd0;
        end else if (accept) begin
          if (tgt_open) begin
            row_d = tgt_row;
            col_d = tgt_col;
            if (moves_q != '1) moves_d = moves_q + 1'b1;
            if ({tgt_row, tgt_col} == end_q) state_d = WON;
          end else begin
            bump_d = 1'b1;
          end
        end
      end
      default: begin
        if (load) begin
          state_d = FETCH;
          fcnt_d  = 4'd0;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= 4'd0;
      maze_q  <= '0;
      start_q <= 6'd0;
      end_q   <= 6'd0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      moves_q <= '0;
      bump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      maze_q  <= maze_d;
      start_q <= start_d;
      end_q   <= end_d;
      row_q   <= row_d;
      col_q   <= col_d;
      moves_q <= moves_d;
      bump_q  <= bump_d;
    end
  end

endmodule

// File: tb/tb_maze_loader.sv
// tb/tb_maze_loader.sv - scoreboard bench for maze_loader
module tb_maze_loader;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic          rom_en;
  logic [3:0]    rom_addr;
  logic [7:0]    rom_data = 8'd0;
  logic          move_valid = 1'b0;
  logic [1:0]    move_dir = 2'd0;
  logic          move_ready;
  logic [2:0]    pos_row, pos_col;
  logic          ready, win, bump;
  logic [CW-1:0] move_count;

  int n_checks = 0;
  int n_errors = 0;

  maze_loader #(.MOVE_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .move_valid(move_valid), .move_dir(move_dir),
    .move_ready(move_ready), .pos_row(pos_row), .pos_col(pos_col), .ready(ready),
    .win(win), .bump(bump), .move_count(move_count)
  );

  always #5 clk = ~clk;

  // Registered map ROM
  logic [7:0] rom [16];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  typedef struct {
    string name;
    int    row;
    int    col;
    int    bmp;
    int    wn;
    int    cnt;
    int    mrdy;
  } exp_t;

  exp_t move_q[$];
  exp_t load_q[$];
  int   addr_q[$];
  exp_t me, le;

  int   cyc = 0;
  int   e0 = 0;
  logic hs_pend = 1'b0, hs_prev = 1'b0, ready_prev = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    hs_pend <= rst_n && move_valid && move_ready && !load;
    hs_prev <= hs_pend;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a ROM read, a move response or ready rising
  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_en) begin
        if (addr_q.size() == 0) chk("rom_en_unexpected", 1, 0);
        else chk("rom_addr", {28'd0, rom_addr}, addr_q.pop_front());
      end
      if (hs_pend) begin
        if (move_q.size() == 0) chk("move_unexpected", 1, 0);
        else begin
          me = move_q.pop_front();
          chk({me.name, "_row"},  {29'd0, pos_row}, me.row);
          chk({me.name, "_col"},  {29'd0, pos_col}, me.col);
          chk({me.name, "_bump"}, {31'd0, bump}, me.bmp);
          chk({me.name, "_win"},  {31'd0, win}, me.wn);
          chk({me.name, "_cnt"},  {29'd0, move_count}, me.cnt);
          chk({me.name, "_mrdy"}, {31'd0, move_ready}, me.mrdy);
        end
      end else if (hs_prev) begin
        chk("bump_width", {31'd0, bump}, 0);
      end
      if (ready && !ready_prev) begin
        if (load_q.size() == 0) chk("ready_unexpected", 1, 0);
        else begin
          le = load_q.pop_front();
          chk({le.name, "_latency"}, cyc - e0, 11);
          chk({le.name, "_row"},  {29'd0, pos_row}, le.row);
          chk({le.name, "_col"},  {29'd0, pos_col}, le.col);
          chk({le.name, "_win"},  {31'd0, win}, le.wn);
          chk({le.name, "_cnt"},  {29'd0, move_count}, 0);
          chk({le.name, "_mrdy"}, {31'd0, move_ready}, le.mrdy);
        end
      end
    end
    ready_prev <= ready;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_addrs();
    for (int i = 0; i < 10; i++) addr_q.push_back(i);
  endtask

  task automatic do_load(input string name, input int r, input int c, input int w, input logic with_move);
    load = 1'b1;
    if (with_move) begin
      move_valid = 1'b1;
      move_dir   = 2'b10;
    end
    push_addrs();
    load_q.push_back('{name, r, c, 0, w, 0, (w != 0) ? 0 : 1});
    @(posedge clk);
    #1;
    e0 = cyc;
    load = 1'b0;
    move_valid = 1'b0;
    repeat (12) tick();
  endtask

  task automatic do_move(input string name, input logic [1:0] dir, input int r, input int c,
                         input int b, input int w, input int n);
    move_valid = 1'b1;
    move_dir   = dir;
    move_q.push_back('{name, r, c, b, w, n, (w != 0) ? 0 : 1});
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_rom(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                         input logic [7:0] r3, input logic [7:0] r4, input logic [7:0] r5,
                         input logic [7:0] r6, input logic [7:0] r7, input logic [7:0] s,
                         input logic [7:0] e);
    rom[0] = r0; rom[1] = r1; rom[2] = r2; rom[3] = r3;
    rom[4] = r4; rom[5] = r5; rom[6] = r6; rom[7] = r7;
    rom[8] = s;  rom[9] = e;
    for (int i = 10; i < 16; i++) rom[i] = 8'h00;
  endtask

  initial begin
    int  found;
    set_rom(8'h3F, 8'h61, 8'h4D, 8'hE5, 8'hB7, 8'h11, 8'hF7, 8'h8C, 8'h38, 8'h07);
    repeat (3) tick();
    chk("reset_outputs", {16'd0, rom_en, rom_addr, move_ready, pos_row, pos_col, ready, win, bump, move_count}, 0);
    rst_n = 1'b1;
    tick();

    do_load("load_a", 7, 0, 0, 1'b0);
    do_move("blk_left",  2'b10, 7, 0, 1, 0, 0);
    do_move("blk_down",  2'b01, 7, 0, 1, 0, 0);
    do_move("blk_right", 2'b11, 7, 0, 1, 0, 0);
    do_move("open_up",   2'b00, 6, 0, 0, 0, 1);
    do_move("blk_up",    2'b00, 6, 0, 1, 0, 1);
    do_move("open_rt",   2'b11, 6, 1, 0, 0, 2);

    // Load together with a move that would otherwise succeed (6,1)->(6,0)
    load = 1'b1;
    move_valid = 1'b1;
    move_dir = 2'b10;
    push_addrs();
    load_q.push_back('{"load_prio", 7, 0, 0, 0, 0, 1});
    @(posedge clk);
    #1;
    e0 = cyc;
    load = 1'b0;
    move_valid = 1'b0;
    tick();
    chk("prio_pos", {26'd0, pos_row, pos_col}, {26'd0, 3'd6, 3'd1});
    chk("prio_ready", {31'd0, ready}, 0);
    chk("prio_rom_en", {31'd0, rom_en}, 1);
    repeat (11) tick();

    set_rom(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    do_load("load_win", 0, 0, 0, 1'b0);
    do_move("win_move", 2'b11, 0, 1, 0, 1, 1);
    move_valid = 1'b1;
    move_dir = 2'b10;
    repeat (3) tick();
    move_valid = 1'b0;
    chk("won_hold", {24'd0, pos_row, pos_col, win, move_ready, move_count}, {24'd0, 3'd0, 3'd1, 1'b1, 1'b0, 3'd1});

    set_rom(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h52, 8'hD2);
    do_load("load_same", 2, 2, 1, 1'b0);

    set_rom(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h3F);
    do_load("load_sat", 0, 0, 0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      if (k % 2 == 1) do_move("sat_rt", 2'b11, 0, 1, 0, 0, (k > 7) ? 7 : k);
      else            do_move("sat_lt", 2'b10, 0, 0, 0, 0, (k > 7) ? 7 : k);
    end

    // Reset while the fetch is at address 5, with load held through the reset edge
    load = 1'b1;
    push_addrs();
    @(posedge clk);
    #1;
    load = 1'b0;
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      tick();
      if (rom_en && rom_addr == 4'd5) found = 1;
    end
    chk("reach_addr5", found, 1);
    rst_n = 1'b0;
    load = 1'b1;
    tick();
    chk("rst_mid_rom_en", {31'd0, rom_en}, 0);
    chk("rst_mid_ready", {31'd0, ready}, 0);
    chk("rst_mid_pos", {26'd0, pos_row, pos_col}, 0);
    addr_q.delete();
    rst_n = 1'b1;
    load = 1'b0;
    repeat (5) tick();
    chk("rst_no_advance", {30'd0, rom_en, ready}, 0);
    do_load("load_after_rst", 0, 0, 0, 1'b0);

    repeat (3) tick();
    chk("queues_drained", move_q.size() + load_q.size() + addr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
